// File: rtl/alu_pkg.sv
// Shared types and constants for the rv_alu datapath block.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_SLL  = 3'b111
  } alu_op_e;

  // Ops that need the adder in subtract mode (difference or compare).
  function automatic logic op_is_sub(input alu_op_e op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared 33-bit add/subtract unit; feeds ADD, SUB and both compares.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sub,
  output logic [XLEN-1:0] sum,
  output logic            borrow,
  output logic            signed_lt
);

  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   total;
  logic            carry;
  logic            ovf;

  // a - b is formed as a + ~b + 1 so one carry chain serves both modes.
  assign b_eff = b ^ {XLEN{sub}};
  assign total = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
  assign sum   = total[XLEN-1:0];
  assign carry = total[XLEN];

  // In subtract mode a missing carry-out means a < b unsigned.
  assign borrow = ~carry;

  assign ovf       = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
  assign signed_lt = sum[XLEN-1] ^ ovf;

endmodule

// File: rtl/rv_alu.sv
// 32-bit integer ALU with zero flag. Define ALU_REG_OUT_EN for a 1-cycle
// registered output stage; otherwise the block is purely combinational.
module rv_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      ctrl,
  output logic [XLEN-1:0] rd,
  output logic            z
);

  import alu_pkg::*;

  alu_op_e         op;
  logic            sub;
  logic [XLEN-1:0] sum;
  logic            borrow;
  logic            signed_lt;
  logic [XLEN-1:0] rd_c;
  logic            z_c;

  assign op  = alu_op_e'(ctrl);
  assign sub = op_is_sub(op);

  alu_addsub u_addsub (
    .a         (rs1),
    .b         (rs2),
    .sub       (sub),
    .sum       (sum),
    .borrow    (borrow),
    .signed_lt (signed_lt)
  );

  always_comb begin
    rd_c = sum;
    case (op)
      ALU_ADD:  rd_c = sum;
      ALU_SUB:  rd_c = sum;
      ALU_AND:  rd_c = rs1 & rs2;
      ALU_OR:   rd_c = rs1 | rs2;
      ALU_XOR:  rd_c = rs1 ^ rs2;
      ALU_SLT:  rd_c = {{(XLEN-1){1'b0}}, signed_lt};
      ALU_SLTU: rd_c = {{(XLEN-1){1'b0}}, borrow};
      ALU_SLL:  rd_c = rs1 << rs2[4:0];
      default:  rd_c = sum;
    endcase
  end

  assign z_c = (rd_c == '0);

`ifdef ALU_REG_OUT_EN
  logic [XLEN-1:0] rd_q;
  logic            z_q;

  // Reset value keeps z consistent with rd == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      z_q  <= 1'b1;
    end else begin
      rd_q <= rd_c;
      z_q  <= z_c;
    end
  end

  assign rd = rd_q;
  assign z  = z_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst_n};

  assign rd = rd_c;
  assign z  = z_c;
`endif

endmodule

// File: tb/tb_rv_alu.sv
// Directed-vector bench for rv_alu; covers both the combinational and the
// ALU_REG_OUT_EN build depending on how it is compiled.
module tb_rv_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  ctrl;
  logic [31:0] rd;
  logic        z;

  int n_chk = 0;
  int n_err = 0;

  rv_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rs1   (rs1),
    .rs2   (rs2),
    .ctrl  (ctrl),
    .rd    (rd),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_rd;
    logic        exp_z;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_rd, input logic exp_z);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp_rd = exp_rd; v.exp_z = exp_z;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_REG_OUT_EN
    @(negedge clk);
    ctrl = op; rs1 = a; rs2 = b;
    @(posedge clk);
    #1;
`else
    ctrl = op; rs1 = a; rs2 = b;
    #1;
`endif
  endtask

  initial begin
    // ADD
    add_vec(3'b000, 32'd20,         32'd30,         32'd50,         1'b0);
    add_vec(3'b000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1);
    // SUB
    add_vec(3'b001, 32'd20,         32'd30,         32'hFFFF_FFF6,  1'b0);
    add_vec(3'b001, 32'd30,         32'd30,         32'd0,          1'b1);
    add_vec(3'b001, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0);
    // logic ops
    add_vec(3'b010, 32'd20,         32'd30,         32'd20,         1'b0);
    add_vec(3'b011, 32'd20,         32'd30,         32'd30,         1'b0);
    add_vec(3'b100, 32'd20,         32'd30,         32'd10,         1'b0);
    add_vec(3'b010, 32'h0000_000F,  32'h0000_00F0,  32'd0,          1'b1);
    // compares
    add_vec(3'b101, 32'd20,         32'd30,         32'd1,          1'b0);
    add_vec(3'b110, 32'd20,         32'd30,         32'd1,          1'b0);
    add_vec(3'b101, 32'h8000_0000,  32'd0,          32'd1,          1'b0);
    add_vec(3'b110, 32'h8000_0000,  32'd0,          32'd0,          1'b1);
    add_vec(3'b101, 32'd5,          32'd5,          32'd0,          1'b1);
    add_vec(3'b110, 32'd5,          32'd5,          32'd0,          1'b1);
    add_vec(3'b101, 32'd0,          32'h8000_0000,  32'd0,          1'b1);
    add_vec(3'b110, 32'd0,          32'h8000_0000,  32'd1,          1'b0);
    add_vec(3'b101, 32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          1'b1);
    add_vec(3'b101, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          1'b0);
    // shift
    add_vec(3'b111, 32'd1,          32'd31,         32'h8000_0000,  1'b0);
    add_vec(3'b111, 32'd1,          32'd32,         32'd1,          1'b0);
    add_vec(3'b111, 32'hF0F0_F0F0,  32'd4,          32'h0F0F_0F00,  1'b0);

    rst_n = 1'b0;
    rs1 = 32'd0; rs2 = 32'd0; ctrl = 3'b000;
    #2;

`ifdef ALU_REG_OUT_EN
    rs1 = 32'd20; rs2 = 32'd30;
    #1;
    chk("rst_rd", rd, 32'd0);
    chk("rst_z", {31'b0, z}, 32'd1);
    @(posedge clk);
    #1;
    chk("rst_hold_rd", rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_load_rd", rd, 32'd50);
    chk("first_load_z", {31'b0, z}, 32'd0);
`else
    ctrl = 3'b000; rs1 = 32'd20; rs2 = 32'd30;
    #1;
    chk("rst_ignored_rd", rd, 32'd50);
    rst_n = 1'b1;
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_rd", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_z", i), {31'b0, z}, {31'b0, vecs[i].exp_z});
    end

`ifdef ALU_REG_OUT_EN
    // Latency: a new input must not show before the next posedge.
    @(negedge clk);
    ctrl = 3'b000; rs1 = 32'd1; rs2 = 32'd2;
    #1;
    chk("latency_old_rd", rd, 32'h0F0F_0F00);
    @(posedge clk);
    #1;
    chk("latency_new_rd", rd, 32'd3);
    // Mid-stream reset discards the in-flight result without a clock edge.
    rs1 = 32'd20; rs2 = 32'd30;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", rd, 32'd0);
    chk("mid_rst_z", {31'b0, z}, 32'd1);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_rd", rd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_rd", rd, 32'd50);
`else
    rst_n = 1'b0;
    ctrl = 3'b001; rs1 = 32'd20; rs2 = 32'd30;
    #1;
    chk("comb_rst_low_rd", rd, 32'hFFFF_FFF6);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
